// File: rtl/app_div_pkg.sv
// Shared types and constants for the iterative 16/8 approximate divider.
// approx_lvl() gives the number of low row cells that run approximate in a given iteration.
package app_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER_N     = 8;
    localparam int ITER_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration k uses k approximate LSB cells, capped at approx_max.
    // An exact transaction always uses zero.
    function automatic logic [ITER_W-1:0] approx_lvl(input logic [ITER_W-1:0] iter,
                                                     input logic              app_en,
                                                     input int unsigned       approx_max);
        logic [ITER_W-1:0] cap;
        cap = approx_max[ITER_W-1:0];
        if (!app_en) begin
            return '0;
        end
        if (iter < cap) begin
            return iter;
        end
        return cap;
    endfunction

endpackage

// File: rtl/app_div_seq_ctrl_if.sv
// Operand/result handshake bundle for the iterative divider.
// master = producer/consumer side, slave = divider side.
interface app_div_seq_ctrl_if;
    import app_div_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] x;
    logic [DIVISOR_W-1:0]  y;
    logic                  app_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVISOR_W-1:0]  q;
    logic [DIVISOR_W-1:0]  r;
    logic                  dbz;

    modport master (
        output in_valid, x, y, app_en, out_ready,
        input  in_ready, out_valid, q, r, dbz
    );

    modport slave (
        input  in_valid, x, y, app_en, out_ready,
        output in_ready, out_valid, q, r, dbz
    );

endinterface

// File: rtl/app_div_row.sv
// One restoring-division row: 8 subtract/mux cells with a ripple borrow.
// Cells below lvl use the cheaper approximate equations, the rest are exact.
// The borrow chain is resolved first because every cell's remainder mux
// depends on the row-level quotient bit qs.
module app_div_row
    import app_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   win,
    input  logic [DIVISOR_W-1:0] y,
    input  logic                 bin,
    input  logic [ITER_W-1:0]    lvl,
    output logic                 qs,
    output logic [DIVISOR_W-1:0] rout
);

    logic [DIVISOR_W-1:0] bi_v;
    logic                 bo_top;

    // Borrow ripple, quotient decision, then per-cell remainder select.
    always_comb begin
        logic bc;
        logic a;
        logic b;
        logic apx;
        bi_v   = '0;
        bo_top = 1'b0;
        qs     = 1'b0;
        rout   = '0;
        bc     = bin;
        for (int i = 0; i < DIVISOR_W; i++) begin
            a       = win[i];
            b       = y[i];
            apx     = (i < int'(lvl));
            bi_v[i] = bc;
            if (apx) begin
                bc = bc & (b | ~a);
            end else begin
                bc = (~a & bc) | (~a & b) | (b & bc);
            end
        end
        bo_top = bc;
        qs     = ~bo_top | win[DIVISOR_W];
        for (int i = 0; i < DIVISOR_W; i++) begin
            a   = win[i];
            b   = y[i];
            apx = (i < int'(lvl));
            if (apx) begin
                rout[i] = a | (qs & (b ^ bi_v[i]));
            end else begin
                rout[i] = qs ? (a ^ b ^ bi_v[i]) : a;
            end
        end
    end

endmodule

// File: rtl/app_div_seq_ctrl.sv
// Sequencer for the iterative 16/8 approximate divider: one shared row
// evaluated over 8 cycles, operand/result handshake through app_div_seq_ctrl_if.
// Optional feature macro: DIV_ZERO_CHK_EN (short-circuits y==0 to q=FF, r=x[7:0], dbz=1).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready high, waiting for operands
// RUN   | one row per cycle, iter 0..7, quotient MSB first
// DONE  | result held; out_valid rises one cycle after entry, waits for out_ready
module app_div_seq_ctrl
    import app_div_pkg::*;
#(
    parameter int unsigned APPROX_MAX = 7
)
(
    input  logic               clk,
    input  logic               rst_n,
    app_div_seq_ctrl_if.slave  bus
);

    state_t               state;
    logic [ITER_W-1:0]    iter;
    logic [DIVISOR_W:0]   win;
    logic [6:0]           x_sh;
    logic [DIVISOR_W-1:0] y_r;
    logic                 app_r;
    logic [DIVISOR_W-1:0] q_r;
    logic [DIVISOR_W-1:0] r_r;
    logic                 in_ready_r;
    logic                 out_valid_r;

    logic [ITER_W-1:0]    lvl;
    logic                 qs;
    logic [DIVISOR_W-1:0] rout;

    assign lvl = approx_lvl(iter, app_r, APPROX_MAX);

    app_div_row u_row (
        .win  (win),
        .y    (y_r),
        .bin  (1'b0),
        .lvl  (lvl),
        .qs   (qs),
        .rout (rout)
    );

`ifdef DIV_ZERO_CHK_EN
    logic dbz_r;
`endif

    // Controller FSM with iteration counter, datapath registers and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            iter        <= '0;
            win         <= '0;
            x_sh        <= '0;
            y_r         <= '0;
            app_r       <= 1'b0;
            q_r         <= '0;
            r_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
            dbz_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        y_r        <= bus.y;
                        app_r      <= bus.app_en;
                        win        <= bus.x[DIVIDEND_W-1:7];
                        x_sh       <= bus.x[6:0];
                        q_r        <= '0;
                        iter       <= '0;
                        in_ready_r <= 1'b0;
`ifdef DIV_ZERO_CHK_EN
                        if (bus.y == '0) begin
                            q_r   <= '1;
                            r_r   <= bus.x[DIVISOR_W-1:0];
                            dbz_r <= 1'b1;
                            state <= DONE;
                        end else begin
                            dbz_r <= 1'b0;
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    q_r[ITER_W'(ITER_N - 1) - iter] <= qs;
                    if (iter == ITER_W'(ITER_N - 1)) begin
                        r_r   <= rout;
                        state <= DONE;
                    end else begin
                        win  <= {rout, x_sh[6]};
                        x_sh <= {x_sh[5:0], 1'b0};
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.q         = q_r;
    assign bus.r         = r_r;
`ifdef DIV_ZERO_CHK_EN
    assign bus.dbz       = dbz_r;
`else
    assign bus.dbz       = 1'b0;
`endif

endmodule

// File: tb/tb_app_div_seq_ctrl.sv
// Bench for app_div_seq_ctrl: three instances (APPROX_MAX 0, 3, 7) share one
// stimulus stream; a transaction-level model predicts handshake timing and results.
module tb_app_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid;
    logic        app_en;
    logic        out_ready;
    logic [15:0] x;
    logic [7:0]  y;

    logic [7:0]  q_o [3];
    logic [7:0]  r_o [3];
    logic        ov_o [3];
    logic        ir_o [3];
    logic        dbz_o [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        app_div_seq_ctrl_if bus ();
        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.app_en    = app_en;
        assign bus.out_ready = out_ready;
        assign q_o[g]        = bus.q;
        assign r_o[g]        = bus.r;
        assign ov_o[g]       = bus.out_valid;
        assign ir_o[g]       = bus.in_ready;
        assign dbz_o[g]      = bus.dbz;
        app_div_seq_ctrl #(.APPROX_MAX(g == 0 ? 0 : (g == 1 ? 3 : 7))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    function automatic int amax_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 3 : 7);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Restoring division built from the row cell rules, one row per quotient bit.
    function automatic logic [15:0] model_div(input logic [15:0] xv, input logic [7:0] yv,
                                              input logic app, input int amax);
        logic [8:0] w;
        logic [7:0] qv;
        logic [7:0] ro;
        logic [7:0] rem;
        logic [7:0] bt;
        logic       bi, a, b, qs;
        int         lvl;
        w   = xv[15:7];
        qv  = '0;
        rem = '0;
        for (int k = 0; k < 8; k++) begin
            lvl = app ? ((k < amax) ? k : amax) : 0;
            bi  = 1'b0;
            for (int i = 0; i < 8; i++) begin
                bt[i] = bi;
                a = w[i];
                b = yv[i];
                if (i < lvl) bi = bi & (b | ~a);
                else         bi = (~a & bi) | (~a & b) | (b & bi);
            end
            qs = ~bi | w[8];
            for (int i = 0; i < 8; i++) begin
                a = w[i];
                b = yv[i];
                if (i < lvl) ro[i] = a | (qs & (b ^ bt[i]));
                else         ro[i] = qs ? (a ^ b ^ bt[i]) : a;
            end
            qv[7-k] = qs;
            if (k < 7) w = {ro, xv[6-k]};
            else       rem = ro;
        end
        return {qv, rem};
    endfunction

    // Transaction model: idle/busy, edges since accept, expected results.
    bit         m_idle = 1'b1;
    int         m_cnt  = 0;
    int         m_lat  = 9;
    bit         m_dbz  = 1'b0;
    logic [7:0] m_q [3];
    logic [7:0] m_r [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1;
            m_cnt  = 0;
            m_lat  = 9;
            m_dbz  = 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_cnt  = 0;
                m_lat  = 9;
                m_dbz  = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    {m_q[g], m_r[g]} = model_div(x, y, app_en, amax_of(g));
`ifdef DIV_ZERO_CHK_EN
                    if (y == 8'd0) begin
                        m_q[g] = 8'hFF;
                        m_r[g] = x[7:0];
                    end
`endif
                end
`ifdef DIV_ZERO_CHK_EN
                if (y == 8'd0) begin
                    m_lat = 1;
                    m_dbz = 1'b1;
                end
`endif
            end
        end else if (m_cnt >= m_lat && out_ready) begin
            m_idle = 1'b1;
        end else if (m_cnt < m_lat) begin
            m_cnt++;
        end
    end

    // Every cycle: handshake outputs always, result fields while valid.
    always @(negedge clk) begin
        bit exp_ov;
        exp_ov = !m_idle && (m_cnt >= m_lat);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("in_ready_u%0d", g), 32'(ir_o[g]), 32'(m_idle));
            chk($sformatf("out_valid_u%0d", g), 32'(ov_o[g]), 32'(exp_ov));
            if (exp_ov) begin
                chk($sformatf("q_u%0d", g), 32'(q_o[g]), 32'(m_q[g]));
                chk($sformatf("r_u%0d", g), 32'(r_o[g]), 32'(m_r[g]));
                chk($sformatf("dbz_u%0d", g), 32'(dbz_o[g]), 32'(m_dbz));
            end
        end
    end

    logic [7:0] cap_q [3];
    logic [7:0] cap_r [3];
    logic       cap_dbz;

    task automatic run_txn(input logic [15:0] xv, input logic [7:0] yv, input logic av,
                           input int hold, input bit noise, output int lat);
        int n;
        int edges;
        bit done;
        bit ov_prev;
        n = 0;
        while (!ir_o[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 32'(ir_o[0]), 32'd1);
        x = xv; y = yv; app_en = av; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (noise) begin
            x = 16'($urandom); y = 8'($urandom); app_en = 1'($urandom);
        end
        lat = -1; edges = 0; done = 1'b0;
        while (!done && edges < 60) begin
            if (ov_o[0] && lat < 0) begin
                lat = edges;
                for (int g = 0; g < 3; g++) begin
                    cap_q[g] = q_o[g];
                    cap_r[g] = r_o[g];
                end
                cap_dbz = dbz_o[0];
            end
            if (lat >= 0 && (edges - lat) < hold) out_ready = 1'b0;
            else if (lat >= 0)                     out_ready = noise ? 1'($urandom) : 1'b1;
            else                                   out_ready = noise ? 1'($urandom) : 1'b0;
            if (noise) begin
                in_valid = 1'($urandom);
                x = 16'($urandom);
                y = 8'($urandom);
            end
            ov_prev = ov_o[0];
            @(posedge clk); #1;
            edges++;
            if (ov_prev && out_ready) done = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("handshake_done", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] xv;
        logic [7:0]  yv;
        logic        av;
        logic [15:0] qr;
        in_valid = 1'b0; x = '0; y = '0; app_en = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        cap_dbz = 1'b0;

        // Model pins from hand-computed results
        chk("model_1000_25", 32'(model_div(16'd1000, 8'd25, 1'b0, 7)), 32'h2800);
        chk("model_00ff_10", 32'(model_div(16'h00FF, 8'h10, 1'b0, 7)), 32'h0F0F);
        chk("model_4000_80", 32'(model_div(16'h4000, 8'h80, 1'b1, 7)), 32'h8000);

        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("rst_q", 32'(q_o[g]), 32'd0);
            chk("rst_r", 32'(r_o[g]), 32'd0);
            chk("rst_dbz", 32'(dbz_o[g]), 32'd0);
            chk("rst_out_valid", 32'(ov_o[g]), 32'd0);
            chk("rst_in_ready", 32'(ir_o[g]), 32'd1);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(16'd1000, 8'd25, 1'b0, 0, 1'b0, lat);
        chk("lat_1000_25", 32'(lat), 32'd9);
        chk("q_1000_25", 32'(cap_q[2]), 32'd40);
        chk("r_1000_25", 32'(cap_r[2]), 32'd0);

        run_txn(16'h00FF, 8'h10, 1'b0, 0, 1'b0, lat);
        chk("q_00ff_10", 32'(cap_q[1]), 32'h0F);
        chk("r_00ff_10", 32'(cap_r[1]), 32'h0F);

        run_txn(16'h4000, 8'h80, 1'b1, 0, 1'b0, lat);
        chk("q_4000_80", 32'(cap_q[2]), 32'h80);
        chk("r_4000_80", 32'(cap_r[2]), 32'h00);

        // DONE held 5 cycles with in_valid noise, then released
        run_txn(16'hBEEF, 8'h5A, 1'b1, 5, 1'b1, lat);
        chk("lat_hold", 32'(lat), 32'd9);

        // Asynchronous reset in the middle of an iteration sequence
        x = 16'd1000; y = 8'd25; app_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_q_before_rst", 32'(q_o[0]), 32'h20);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            chk("arst_out_valid", 32'(ov_o[g]), 32'd0);
            chk("arst_q", 32'(q_o[g]), 32'd0);
            chk("arst_r", 32'(r_o[g]), 32'd0);
            chk("arst_in_ready", 32'(ir_o[g]), 32'd1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(16'd1000, 8'd25, 1'b0, 0, 1'b0, lat);
        chk("post_rst_lat", 32'(lat), 32'd9);
        chk("post_rst_q", 32'(cap_q[0]), 32'd40);
        chk("post_rst_r", 32'(cap_r[0]), 32'd0);

        // Divide by zero
        run_txn(16'h1234, 8'h00, 1'b0, 0, 1'b0, lat);
`ifdef DIV_ZERO_CHK_EN
        chk("dbz_lat", 32'(lat), 32'd1);
        chk("dbz_q", 32'(cap_q[0]), 32'hFF);
        chk("dbz_r", 32'(cap_r[0]), 32'h34);
        chk("dbz_flag", 32'(cap_dbz), 32'd1);
`else
        qr = model_div(16'h1234, 8'h00, 1'b0, 0);
        chk("dbz_lat", 32'(lat), 32'd9);
        chk("dbz_flag", 32'(cap_dbz), 32'd0);
        chk("dbz_q", 32'(cap_q[0]), 32'(qr[15:8]));
        chk("dbz_r", 32'(cap_r[0]), 32'(qr[7:0]));
`endif

        // Randomized operands; exact non-overflow cases also pinned to plain arithmetic
        for (int t = 0; t < 2000; t++) begin
            xv = 16'($urandom);
            yv = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            av = 1'($urandom);
            if (!av && yv != 8'd0 && xv[15:8] < yv) begin
                qr = model_div(xv, yv, 1'b0, 7);
                chk("model_vs_arith_q", 32'(qr[15:8]), 32'(xv / 16'(yv)));
                chk("model_vs_arith_r", 32'(qr[7:0]), 32'(xv % 16'(yv)));
            end
            run_txn(xv, yv, av, $urandom_range(0, 2), 1'b1, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
